// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter: FSM state encoding and
// AXI response codes.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_RADDR = 3'd2,
        ST_WRESP = 3'd3,
        ST_RDATA = 3'd4
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant,
// wrapping around, wins. Output is one-hot (all zero when nothing requests).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ simple request ports onto a single
// AXI4-Lite master, one transaction at a time.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,

    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,

    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,

    output logic [2:0]                    dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]     r_grant;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_bready;
    logic                   r_rready;

    logic [NUM_REQ-1:0]     w_pick;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_we;
    logic [ADDR_WIDTH-1:0]  w_pick_addr;
    logic [DATA_WIDTH-1:0]  w_pick_wdata;
    logic                   w_aw_ok;
    logic                   w_w_ok;
    logic                   w_b_hs;
    logic                   w_r_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (r_last_grant),
        .grant      (w_pick)
    );

    always_comb begin
        w_pick_idx   = '0;
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx   = IDX_W'(i);
                w_pick_we    = req_we[i];
                w_pick_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_pick_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A channel transfers on the cycle VALID and READY are both high; VALID
    // never drops before that and its payload is held from r_addr/r_wdata.
    assign w_aw_ok = !r_awvalid || M_AXI_AWREADY;
    assign w_w_ok  = !r_wvalid  || M_AXI_WREADY;
    assign w_b_hs  = r_bready && M_AXI_BVALID;
    assign w_r_hs  = r_rready && M_AXI_RVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_rready     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick_idx;
                        r_addr       <= w_pick_addr;
                        r_wdata      <= w_pick_wdata;
                        if (w_pick_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_RADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_WRESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_bready  <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    // Completion is reported in the response handshake cycle itself.
    assign done      = r_grant & {NUM_REQ{w_b_hs || w_r_hs}};
    assign rsp_rdata = w_r_hs ? M_AXI_RDATA : '0;
    assign rsp_err   = (w_b_hs && resp_is_err(M_AXI_BRESP)) ||
                       (w_r_hs && resp_is_err(M_AXI_RRESP));

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with a small AXI4-Lite slave model whose
// ready delays, response error and B-response hold-off are bench-controlled.
module tb_axil_rr_arbiter;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   awaddr;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic         wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [3:0]   araddr;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid, rready;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axil_rr_arbiter dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready), .dbg_state(dbg_state)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_hold = 0, err_en = 0;
    logic [31:0] mem [4];
    int          aw_cnt, w_cnt, ar_cnt;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wa;
    logic [31:0] s_wd;
    logic        aw_hs, w_hs;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid  && (w_cnt  >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign s_wa    = aw_hs ? awaddr : s_awaddr;
    assign s_wd    = w_hs ? wdata : s_wdata;
    assign bvalid  = b_pend && !b_hold;
    assign bresp   = 2'b00;
    assign rvalid  = r_pend;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
            s_awaddr <= '0; s_wdata <= '0; rdata <= '0; rresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_cnt <= 0; aw_got <= 1; s_awaddr <= awaddr;
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_cnt <= 0; w_got <= 1; s_wdata <= wdata;
            end else if (wvalid) w_cnt <= w_cnt + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[s_wa[3:2]] <= s_wd;
                b_pend <= 1; aw_got <= 0; w_got <= 0;
            end
            if (bvalid && bready) b_pend <= 0;
            if (arvalid && arready) begin
                ar_cnt <= 0; r_pend <= 1;
                rdata  <= mem[araddr[3:2]];
                rresp  <= (err_en && araddr == 4'h8) ? 2'b10 : 2'b00;
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (rvalid && rready) r_pend <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " awvalid"}, 32'(awvalid), 0);
        chk({tag, " wvalid"},  32'(wvalid), 0);
        chk({tag, " arvalid"}, 32'(arvalid), 0);
        chk({tag, " bready"},  32'(bready), 0);
        chk({tag, " rready"},  32'(rready), 0);
        chk({tag, " done"},    32'(done), 0);
        chk({tag, " rdata"},   rsp_rdata, 0);
        chk({tag, " err"},     32'(rsp_err), 0);
        chk({tag, " state"},   32'(dbg_state), 0);
    endtask

    // Called at a negedge with the FSM idle; returns the cycle count to done.
    task automatic do_txn(input int idx, input bit we, input logic [3:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [3:0] dv, output logic [31:0] rd, output logic er);
        req_we[idx] = we;
        req_addr[idx*4 +: 4] = addr;
        req_wdata[idx*32 +: 32] = wd;
        req[idx] = 1'b1;
        lat = 0; dv = '0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge aclk); @(negedge aclk);
            if (done != 0) begin
                lat = c; dv = done; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    typedef struct {
        int          idx;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        bit          err_en;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t        vecs [12];
    logic [3:0]  exp_q [$];
    logic [3:0]  got_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [3:0]  dv;
        logic [31:0] rd;
        logic        er;
        bit          reached;
        int          br_cnt, dn_cnt, dn_k, addr_bad;
        logic [3:0]  e, a;

        vecs[0]  = '{0, 1, 4'h0, 32'h1, 0, 32'h0, 0};
        vecs[1]  = '{0, 1, 4'h4, 32'h2, 0, 32'h0, 0};
        vecs[2]  = '{0, 1, 4'h8, 32'h3, 0, 32'h0, 0};
        vecs[3]  = '{0, 1, 4'hC, 32'h4, 0, 32'h0, 0};
        vecs[4]  = '{0, 0, 4'h0, 32'h0, 0, 32'h1, 0};
        vecs[5]  = '{0, 0, 4'h4, 32'h0, 0, 32'h2, 0};
        vecs[6]  = '{0, 0, 4'h8, 32'h0, 0, 32'h3, 0};
        vecs[7]  = '{0, 0, 4'hC, 32'h0, 0, 32'h4, 0};
        vecs[8]  = '{0, 0, 4'h8, 32'h0, 1, 32'h3, 1};
        vecs[9]  = '{3, 1, 4'h4, 32'hDEADBEEF, 0, 32'h0, 0};
        vecs[10] = '{1, 0, 4'h4, 32'h0, 0, 32'hDEADBEEF, 0};
        vecs[11] = '{2, 0, 4'hC, 32'h0, 0, 32'h4, 0};

        // ---- reset state ----
        aresetn = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge aclk);
        chk_idle_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        chk_idle_outputs("post_reset");

        // ---- single transactions, zero-wait slave ----
        for (int v = 0; v < 12; v++) begin
            err_en = vecs[v].err_en;
            do_txn(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, dv, rd, er);
            chk($sformatf("v%0d latency", v), lat, 2);
            chk($sformatf("v%0d done", v), 32'(dv), 32'(4'b0001 << vecs[v].idx));
            chk($sformatf("v%0d rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("v%0d err", v), 32'(er), 32'(vecs[v].exp_err));
            @(posedge aclk); @(negedge aclk);
            chk($sformatf("v%0d done_pulse", v), 32'(done), 0);
            err_en = 0;
        end

        // ---- round-robin with req=0111 held from reset ----
        aresetn = 1'b0; req_we = '0; req_addr = '0;
        req = 4'b0111;
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        got_q.delete();
        for (int c = 0; c < 100; c++) begin
            @(posedge aclk); @(negedge aclk);
            if (done != 0) got_q.push_back(done);
            if (got_q.size() == 6) break;
        end
        req = '0;
        chk("rr done count", got_q.size(), 6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            a = (got_q.size() > 0) ? got_q.pop_front() : 4'hF;
            chk($sformatf("rr order %0d", i), 32'(a), 32'(e));
        end
        repeat (2) @(negedge aclk);

        // ---- WREADY at grant+1, AWREADY at grant+4 ----
        aw_dly = 3;
        req_we[1] = 1'b1; req_addr[7:4] = 4'h0; req_wdata[63:32] = 32'h55;
        req[1] = 1'b1;
        br_cnt = 0; dn_cnt = 0; dn_k = 0; addr_bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge aclk); @(negedge aclk);
            if (k == 1) chk("split wvalid@1", 32'(wvalid), 1);
            if (k == 1) chk("split wdata@1", wdata, 32'h55);
            if (k == 2) chk("split wvalid@2", 32'(wvalid), 0);
            if (k == 4) chk("split awvalid@4", 32'(awvalid), 1);
            if (k == 5) chk("split awvalid@5", 32'(awvalid), 0);
            if (awvalid && awaddr != 4'h0) addr_bad++;
            if (bready) br_cnt++;
            if (done != 0) begin
                dn_cnt++; dn_k = k;
                chk("split done vec", 32'(done), 32'(4'b0010));
                req[1] = 1'b0;
            end
        end
        chk("split addr stable", addr_bad, 0);
        chk("split bready beats", br_cnt, 1);
        chk("split done count", dn_cnt, 1);
        chk("split done cycle", dn_k, 5);
        aw_dly = 0;

        // ---- reset while waiting for BVALID ----
        b_hold = 1;
        req_we[2] = 1'b1; req_addr[11:8] = 4'hC; req_wdata[95:64] = 32'h77;
        req[2] = 1'b1;
        reached = 0; dn_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge aclk); @(negedge aclk);
            if (done != 0) dn_cnt++;
            if (dbg_state == 3'd3) begin
                reached = 1;
                break;
            end
        end
        chk("wresp reached", 32'(reached), 1);
        repeat (2) begin
            @(posedge aclk); @(negedge aclk);
            if (done != 0) dn_cnt++;
        end
        chk("wresp bready held", 32'(bready), 1);
        #2;
        aresetn = 1'b0;
        req = '0;
        #1;
        chk_idle_outputs("mid_reset");
        chk("mid_reset no done", dn_cnt, 0);
        @(negedge aclk);
        b_hold = 0;
        aresetn = 1'b1;
        req_we = '0; req_addr = '0;
        req = 4'b1111;
        dv = '0; rd = '0;
        for (int c = 0; c < 50; c++) begin
            @(posedge aclk); @(negedge aclk);
            if (done != 0) begin
                dv = done; rd = rsp_rdata;
                break;
            end
        end
        req = '0;
        chk("post_reset first grant", 32'(dv), 32'(4'b0001));
        chk("post_reset read data", rd, 32'h55);
        repeat (3) @(negedge aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_rr_arbiter.md
AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, byte address width (4 x 32-bit registers).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-004 ACLK  in  1  sole clock, rising edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester access request, level.
REQ-007 req_we  in  NUM_REQ  1=write, 0=read.
REQ-008 req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester byte address.
REQ-009 req_wdata  in  NUM_REQ*DATA_WIDTH  packed per-requester write data.
REQ-010 done  out  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 rsp_rdata  out  DATA_WIDTH  read data, valid while done nonzero.
REQ-012 rsp_err  out  1  1 if RESP was SLVERR/DECERR, valid while done nonzero.
REQ-013 M_AXI_AWADDR / M_AXI_AWVALID / M_AXI_AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel.
REQ-014 M_AXI_WDATA / M_AXI_WVALID / M_AXI_WREADY  out/out/in  DATA_WIDTH/1/1  write data channel; WSTRB tied all-ones by the interconnect.
REQ-015 M_AXI_BRESP / M_AXI_BVALID / M_AXI_BREADY  in/in/out  2/1/1  write response channel.
REQ-016 M_AXI_ARADDR / M_AXI_ARVALID / M_AXI_ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel.
REQ-017 M_AXI_RDATA / M_AXI_RRESP / M_AXI_RVALID / M_AXI_RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel.

Function
REQ-018 SHALL implement FSM IDLE -> WADDR (write) or RADDR (read) -> WRESP or RDATA -> IDLE.
REQ-019 IDLE: if any req high, SHALL grant one index round-robin, latch its we/addr/wdata, and assert AWVALID+WVALID or ARVALID the next cycle.
REQ-020 Round-robin: highest priority is index (last_grant+1) mod NUM_REQ; after reset, index 0 is highest.
REQ-021 WADDR: AWVALID and WVALID SHALL each deassert independently on their own handshake; move to WRESP when both have completed (same or different cycles).
REQ-022 VALID signals SHALL NOT drop before their READY handshake; address/data SHALL be stable while VALID is high.
REQ-023 BREADY SHALL be high only in WRESP; RREADY only in RDATA; each accepts exactly one beat.
REQ-024 On B/R handshake, done[grant] SHALL pulse that cycle with rsp_rdata (RDATA, or 0 for writes) and rsp_err=RESP[1]; FSM returns to IDLE.
REQ-025 Requester SHALL hold req/we/addr/wdata until done; req still high in the cycle after done is treated as a new request.
REQ-026 Dropping req after grant SHALL NOT abort; the transaction completes and done still pulses.
REQ-027 At most one AXI transaction outstanding; write and read never overlap.
REQ-028 Minimum latency: req at cycle t in IDLE, all READYs high -> done at t+2 (grant t, address t+1, response t+2 at earliest).

Reset
REQ-029 ARESETN low SHALL immediately force IDLE, last_grant=NUM_REQ-1, and all VALID/READY, done, rsp_rdata, rsp_err to 0, including mid-transaction (no completion reported).

Structure
REQ-030 FSM state enum and AXI RESP constants SHALL live in shared package axil_arb_pkg; the round-robin priority picker SHALL be sub-module rr_pick (req vector + last grant in, one-hot grant out, combinational).

Verification
REQ-031 Requester 0 writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads them back -> each read done with rsp_rdata matching, rsp_err=0.
REQ-032 req=4'b0111 held continuously from reset -> done order 0,1,2,0,1,2; requester 3 never granted.
REQ-033 WREADY at grant+1, AWREADY at grant+4 -> WVALID drops after grant+1, AWVALID held to grant+4, single BREADY beat, one done.
REQ-034 Slave returns RRESP=2'b10 on read of 0x8 -> done pulse with rsp_err=1.
REQ-035 ARESETN asserted while in WRESP before BVALID -> all outputs 0 at once, no done pulse; next request after release granted to index 0 first.
